gate_vector_checker: RTL and testbench

Synthesizable exhaustive stimulus generator and response checker for the small combinational gate modules in the andTest/ortest family. It drives every input combination of an N-input gate in ascending binary order, waits a settle window, samples the gate output and compares it against a built-in reference function. It reports a mismatch count, the first failing vector and a final pass/fail. The block sits directly upstream of the gate under test, feeding it, and directly downstream of it, consuming its output.

---
 rtl/gate_vector_checker_pkg.sv | 22 ++
 rtl/gate_vector_checker_ref_model.sv | 26 ++
 rtl/gate_vector_checker.sv | 99 +++++++++
 tb/tb_gate_vector_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for the gate vector checker: reference-function encodings,
// FSM state encoding and the settle counter width.
package gate_vector_checker_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;

    // SETTLE_CYC tops out at 15, so four bits hold any reload value.
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_vector_checker_ref_model.sv
// Combinational golden model of an N-input gate, built from reduction operators.
// Shared between the checker and the gate testbenches.
module gate_ref_model
    import gate_vector_checker_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int GATE_OP = OP_OR
) (
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        case (GATE_OP)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_XOR:  expected = ^vec;
            OP_NAND: expected = ~&vec;
            OP_NOR:  expected = ~|vec;
            OP_XNOR: expected = ~^vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive sweep generator and response checker for a small N-input gate:
// drives every vector in ascending order, waits a settle window, checks the output.
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int GATE_OP    = OP_OR,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_seen
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]         LAST_VEC    = '1;

    state_t                  state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    expected;
    logic                    mismatch;

    gate_ref_model #(
        .N_IN    (N_IN),
        .GATE_OP (GATE_OP)
    ) u_ref (
        .vec      (dut_in),
        .expected (expected)
    );

    assign mismatch = (dut_out != expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_SETTLE;
                        settle_cnt     <= SETTLE_LOAD;
                        dut_in         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        fail_seen      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_seen) begin
                            first_fail_vec <= dut_in;
                            fail_seen      <= 1'b1;
                        end
                    end
                    // The all-ones vector ends the sweep; dut_in never wraps.
                    if (dut_in == LAST_VEC) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state      <= ST_SETTLE;
                        dut_in     <= dut_in + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: four checker instances with different gates and
// settle windows, each feeding a modelled gate whose faults the bench controls.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a [4];
    logic       dout_a  [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic       pass_a  [4];
    logic       fs_a    [4];
    logic [7:0] din_a   [4];
    logic [8:0] ec_a    [4];
    logic [7:0] ffv_a   [4];

    int           fault [4];
    logic [255:0] flip  [4];

    logic [1:0] din0, ffv0;  logic [2:0] ec0;
    logic [2:0] din1, ffv1;  logic [3:0] ec1;
    logic [1:0] din2, ffv2;  logic [2:0] ec2;
    logic [3:0] din3, ffv3;  logic [4:0] ec3;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int nin_of(int i);
        case (i) 0: return 2; 1: return 3; 2: return 2; default: return 4; endcase
    endfunction
    function automatic int op_of(int i);
        case (i) 0: return 1; 1: return 0; 2: return 3; default: return 2; endcase
    endfunction
    function automatic int scyc_of(int i);
        case (i) 0: return 1; 1: return 2; 2: return 1; default: return 3; endcase
    endfunction

    // Reference truth from the count of ones in the vector.
    function automatic logic ref_bit(int op, int n, int v);
        int ones = 0;
        for (int b = 0; b < n; b++) ones += (v >> b) & 1;
        case (op)
            0:       return ones == n;
            1:       return ones > 0;
            2:       return (ones % 2) == 1;
            3:       return ones != n;
            4:       return ones == 0;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    // Gate under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 acts as OR, 4 random flips.
    function automatic logic gut_eval(int f, int op, int n, int v, logic [255:0] fl);
        case (f)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ref_bit(1, n, v);
            4:       return ref_bit(op, n, v) ^ fl[v[7:0]];
            default: return ref_bit(op, n, v);
        endcase
    endfunction

    assign din_a[0] = 8'(din0);  assign ffv_a[0] = 8'(ffv0);  assign ec_a[0] = 9'(ec0);
    assign din_a[1] = 8'(din1);  assign ffv_a[1] = 8'(ffv1);  assign ec_a[1] = 9'(ec1);
    assign din_a[2] = 8'(din2);  assign ffv_a[2] = 8'(ffv2);  assign ec_a[2] = 9'(ec2);
    assign din_a[3] = 8'(din3);  assign ffv_a[3] = 8'(ffv3);  assign ec_a[3] = 9'(ec3);

    for (genvar gi = 0; gi < 4; gi++) begin : g_gut
        assign dout_a[gi] = gut_eval(fault[gi], op_of(gi), nin_of(gi), int'(din_a[gi]), flip[gi]);
    end

    gate_vector_checker #(.N_IN(2), .GATE_OP(1), .SETTLE_CYC(1)) u_or (
        .clk(clk), .rst(rst), .start(start_a[0]), .dut_in(din0), .dut_out(dout_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .err_count(ec0),
        .first_fail_vec(ffv0), .fail_seen(fs_a[0]));

    gate_vector_checker #(.N_IN(3), .GATE_OP(0), .SETTLE_CYC(2)) u_and (
        .clk(clk), .rst(rst), .start(start_a[1]), .dut_in(din1), .dut_out(dout_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .err_count(ec1),
        .first_fail_vec(ffv1), .fail_seen(fs_a[1]));

    gate_vector_checker #(.N_IN(2), .GATE_OP(3), .SETTLE_CYC(1)) u_nand (
        .clk(clk), .rst(rst), .start(start_a[2]), .dut_in(din2), .dut_out(dout_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .err_count(ec2),
        .first_fail_vec(ffv2), .fail_seen(fs_a[2]));

    gate_vector_checker #(.N_IN(4), .GATE_OP(2), .SETTLE_CYC(3)) u_xor (
        .clk(clk), .rst(rst), .start(start_a[3]), .dut_in(din3), .dut_out(dout_a[3]),
        .busy(busy_a[3]), .done(done_a[3]), .pass(pass_a[3]), .err_count(ec3),
        .first_fail_vec(ffv3), .fail_seen(fs_a[3]));

    task automatic chk(string nm, int i, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic chk_idle(int i);
        chk("rst_din", i, int'(din_a[i]), 0);
        chk("rst_busy", i, int'(busy_a[i]), 0);
        chk("rst_done", i, int'(done_a[i]), 0);
        chk("rst_pass", i, int'(pass_a[i]), 0);
        chk("rst_err", i, int'(ec_a[i]), 0);
        chk("rst_ffv", i, int'(ffv_a[i]), 0);
        chk("rst_fs", i, int'(fs_a[i]), 0);
    endtask

    task automatic model_expect(int i, output int ee, output int ef);
        int n = nin_of(i);
        ee = 0;
        ef = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gut_eval(fault[i], op_of(i), n, v, flip[i]) != ref_bit(op_of(i), n, v)) begin
                if (ee == 0) ef = v;
                ee++;
            end
        end
    endtask

    // Called #1 after the accepting edge k; follows the sweep cycle by cycle to done.
    task automatic sweep_body(int i, int ee, int ef, bit poke);
        int s = scyc_of(i);
        int n = nin_of(i);
        int t = (1 << n) * (s + 1);
        for (int c = 0; c <= t; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c < t) begin
                chk("din_step", i, int'(din_a[i]), c / (s + 1));
                chk("busy", i, int'(busy_a[i]), 1);
                chk("done_early", i, int'(done_a[i]), 0);
                if (c == 0) begin
                    chk("clr_err", i, int'(ec_a[i]), 0);
                    chk("clr_fs", i, int'(fs_a[i]), 0);
                    chk("clr_ffv", i, int'(ffv_a[i]), 0);
                end
            end else begin
                chk("done", i, int'(done_a[i]), 1);
                chk("busy_end", i, int'(busy_a[i]), 0);
                chk("din_last", i, int'(din_a[i]), (1 << n) - 1);
                chk("err_count", i, int'(ec_a[i]), ee);
                chk("first_fail", i, int'(ffv_a[i]), ef);
                chk("fail_seen", i, int'(fs_a[i]), (ee != 0) ? 1 : 0);
                chk("pass", i, int'(pass_a[i]), (ee == 0) ? 1 : 0);
            end
            if (poke && c == 3) start_a[i] = 1'b1;
            if (poke && c == 4) start_a[i] = 1'b0;
        end
    endtask

    task automatic launch(int i, int ee, int ef, bit poke);
        start_a[i] = 1'b1;
        @(posedge clk);
        #1;
        start_a[i] = 1'b0;
        sweep_body(i, ee, ef, poke);
    endtask

    typedef struct {
        int inst;
        int flt;
        int exp_err;
        int exp_ffv;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ee, ef;
        tbl[0] = '{inst: 0, flt: 0, exp_err: 0, exp_ffv: 0};  // OR, correct gate
        tbl[1] = '{inst: 0, flt: 1, exp_err: 3, exp_ffv: 1};  // OR, stuck-at-0
        tbl[2] = '{inst: 1, flt: 3, exp_err: 6, exp_ffv: 1};  // AND checker, gate is OR
        tbl[3] = '{inst: 2, flt: 2, exp_err: 1, exp_ffv: 3};  // NAND, stuck-at-1
        tbl[4] = '{inst: 1, flt: 0, exp_err: 0, exp_ffv: 0};  // AND, correct gate
        tbl[5] = '{inst: 2, flt: 1, exp_err: 3, exp_ffv: 0};  // NAND, stuck-at-0

        for (int i = 0; i < 4; i++) begin
            start_a[i] = 1'b0;
            fault[i]   = 0;
            flip[i]    = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_idle(i);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 6; r++) begin
            fault[tbl[r].inst] = tbl[r].flt;
            launch(tbl[r].inst, tbl[r].exp_err, tbl[r].exp_ffv, 1'b0);
            @(posedge clk);
            #1;
        end

        // Reset while settling on vector 2 aborts the sweep and clears everything.
        fault[0] = 1;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_din", 0, int'(din_a[0]), 2);
        chk("mid_err", 0, int'(ec_a[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle(0);
        fault[0] = 0;
        launch(0, 0, 0, 1'b0);

        // start pulsed while busy is ignored; DONE then holds with start low.
        fault[1] = 3;
        launch(1, 6, 1, 1'b1);
        @(posedge clk);
        #1;
        chk("done_hold", 1, int'(done_a[1]), 1);
        chk("err_hold", 1, int'(ec_a[1]), 6);

        // start held high: DONE lasts one cycle, then a fresh sweep with cleared results.
        fault[2] = 2;
        start_a[2] = 1'b1;
        @(posedge clk);
        #1;
        sweep_body(2, 1, 3, 1'b0);
        fault[2] = 0;
        @(posedge clk);
        #1;
        start_a[2] = 1'b0;
        sweep_body(2, 0, 0, 1'b0);

        // Randomised gate faults against the count-of-ones reference.
        for (int r = 0; r < 8; r++) begin
            int i = int'($urandom_range(0, 3));
            fault[i] = int'($urandom_range(0, 4));
            flip[i]  = 256'($urandom);
            model_expect(i, ee, ef);
            launch(i, ee, ef, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
